kb_move_entry: RTL

- Decodes PS/2 scan-code bytes from the keyboard block into chess-cursor navigation and move selection.
- Sits between keyboard and the game-logic/AI_Engine path.
- Keeps an 8x8 cursor, captures a source square and a destination square with ENTER, and cancels with ESC.
- Issues a valid/ready move request; game logic consumes it.

---
 rtl/kb_move_if.sv | 23 ++
 rtl/kb_move_entry.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/kb_move_if.sv
// Move-request bus between the keyboard move-entry block (master) and game logic (slave).
// Handshake: the master raises move_valid with src_loc/dst_loc stable and holds them
// until a clock edge samples move_valid & move_ready; the transfer completes on that edge.
interface kb_move_if;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] src_loc;
    logic [5:0] dst_loc;

    modport master (
        output move_valid,
        output src_loc,
        output dst_loc,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  src_loc,
        input  dst_loc,
        output move_ready
    );
endinterface

// File: rtl/kb_move_entry.sv
// PS/2 scan-code decoder driving an 8x8 chess cursor and a source/destination move request.
// Optional typematic suppression is enabled by defining KB_REPEAT_FILTER_EN.
module kb_move_entry #(
    parameter int CURSOR_RST_X = 4,
    parameter int CURSOR_RST_Y = 1,
    parameter bit WRAP         = 1'b1
) (
    input  logic        clk50,
    input  logic        RST,
    input  logic [7:0]  scan_code1,
    input  logic [7:0]  scan_code2,
    input  logic        scan_ready,
    input  logic        en,
    output logic [5:0]  cursor_loc,
    output logic        src_held,
    output logic        key_evt,
    output logic [1:0]  state_dbg,
    kb_move_if.master   mv
);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_UP    = 8'h1D;
    localparam logic [7:0] CODE_DOWN  = 8'h1B;
    localparam logic [7:0] CODE_LEFT  = 8'h1C;
    localparam logic [7:0] CODE_RIGHT = 8'h23;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    typedef enum logic [1:0] {
        SEL_SRC = 2'd0,
        SEL_DST = 2'd1,
        REQ     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cx_q, cx_d;
    logic [2:0] cy_q, cy_d;
    logic [5:0] src_q, src_d;
    logic [5:0] dst_q, dst_d;
    logic       held_q, held_d;
    logic       valid_q, valid_d;
    logic       key_evt_q;
    logic       scan_ready_q;

    logic       evt;
    logic       is_make;
    logic       repeat_hit;
    logic       accept;

    function automatic logic [2:0] step_up(input logic [2:0] v);
        if (WRAP || v != 3'd7)
            step_up = v + 3'd1;
        else
            step_up = v;
    endfunction

    function automatic logic [2:0] step_down(input logic [2:0] v);
        if (WRAP || v != 3'd0)
            step_down = v - 3'd1;
        else
            step_down = v;
    endfunction

    // One event per rising edge of the keyboard's scan_ready level.
    assign evt     = scan_ready & ~scan_ready_q;
    assign is_make = (scan_code1 != CODE_BREAK) && (scan_code1 != CODE_EXT) &&
                     (scan_code2 != CODE_BREAK);

`ifdef KB_REPEAT_FILTER_EN
    logic [7:0] last_make_q;
    logic       break_clr;

    assign repeat_hit = (scan_code1 == last_make_q);
    assign break_clr  = evt && (scan_code2 == CODE_BREAK) && (scan_code1 == last_make_q);

    always_ff @(posedge clk50 or posedge RST) begin
        if (RST)
            last_make_q <= 8'h00;
        else if (accept)
            last_make_q <= scan_code1;
        else if (break_clr)
            last_make_q <= 8'h00;
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign accept = evt & is_make & en & (state_q != REQ) & ~repeat_hit;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        src_d   = src_q;
        dst_d   = dst_q;
        held_d  = held_q;
        valid_d = valid_q;

        if (accept) begin
            case (scan_code1)
                CODE_UP:    cy_d = step_up(cy_q);
                CODE_DOWN:  cy_d = step_down(cy_q);
                CODE_LEFT:  cx_d = step_down(cx_q);
                CODE_RIGHT: cx_d = step_up(cx_q);
                default:    ;
            endcase
        end

        case (state_q)
            SEL_SRC: begin
                if (accept && scan_code1 == CODE_ENTER) begin
                    src_d   = {cy_q, cx_q};
                    held_d  = 1'b1;
                    state_d = SEL_DST;
                end
            end
            SEL_DST: begin
                if (accept && scan_code1 == CODE_ENTER) begin
                    if ({cy_q, cx_q} == src_q) begin
                        held_d  = 1'b0;
                        state_d = SEL_SRC;
                    end else begin
                        dst_d   = {cy_q, cx_q};
                        valid_d = 1'b1;
                        state_d = REQ;
                    end
                end else if (accept && scan_code1 == CODE_ESC) begin
                    held_d  = 1'b0;
                    state_d = SEL_SRC;
                end
            end
            REQ: begin
                if (mv.move_ready) begin
                    valid_d = 1'b0;
                    held_d  = 1'b0;
                    state_d = SEL_SRC;
                end
            end
            default: begin
                state_d = SEL_SRC;
                held_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk50 or posedge RST) begin
        if (RST) begin
            state_q      <= SEL_SRC;
            cx_q         <= 3'(CURSOR_RST_X);
            cy_q         <= 3'(CURSOR_RST_Y);
            src_q        <= 6'd0;
            dst_q        <= 6'd0;
            held_q       <= 1'b0;
            valid_q      <= 1'b0;
            key_evt_q    <= 1'b0;
            scan_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            held_q       <= held_d;
            valid_q      <= valid_d;
            key_evt_q    <= accept;
            scan_ready_q <= scan_ready;
        end
    end

    assign cursor_loc    = {cy_q, cx_q};
    assign src_held      = held_q;
    assign key_evt       = key_evt_q;
    assign state_dbg     = state_q;
    assign mv.move_valid = valid_q;
    assign mv.src_loc    = src_q;
    assign mv.dst_loc    = dst_q;

endmodule
